stream_pool_layer: RTL and testbench

//  Streaming, parametrised 2-D pooling stage placed between the ReLU stage and the next conv/FC stage.
//  - Input: one raster-order pixel per handshake, all CHANNELS packed into one word.
//  - Output: the pooled stream, one word per non-overlapping STRIDE x STRIDE window.
//  - Storage is a single line buffer of partial window results, not full frames.
//  - Max pooling always; average pooling as a compile-time option.

---
 rtl/cnn_pool_pkg.sv | 18 +
 rtl/pool_reduce.sv | 24 ++
 rtl/stream_pool_layer.sv | 183 ++++++++++++++++++
 tb/tb_stream_pool_layer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pool_pkg.sv
// Shared types and helpers for the streaming pooling stage.
package cnn_pool_pkg;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_e;
    typedef enum logic {POOL_MAX, POOL_AVG} mode_e;

    function automatic int clog2_stride(input int stride);
        return $clog2(stride);
    endfunction

    // Pooled frame geometry for the reference configuration.
    localparam int DEF_IN_X   = 24;
    localparam int DEF_IN_Y   = 24;
    localparam int DEF_STRIDE = 2;
    localparam int OUT_X      = DEF_IN_X / DEF_STRIDE;
    localparam int OUT_Y      = DEF_IN_Y / DEF_STRIDE;

endpackage

// File: rtl/pool_reduce.sv
// Per-channel combine of two packed words: maximum, or sum in average mode.
module pool_reduce
    import cnn_pool_pkg::*;
#(
    parameter int W        = 8,
    parameter int CHANNELS = 1
) (
    input  mode_e                   mode,
    input  logic [CHANNELS*W-1:0]   a,
    input  logic [CHANNELS*W-1:0]   b,
    output logic [CHANNELS*W-1:0]   y
);

    always_comb begin
        y = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (mode == POOL_AVG)
                y[c*W +: W] = a[c*W +: W] + b[c*W +: W];
            else
                y[c*W +: W] = (a[c*W +: W] > b[c*W +: W]) ? a[c*W +: W] : b[c*W +: W];
        end
    end

endmodule

// File: rtl/stream_pool_layer.sv
// Streaming STRIDE x STRIDE pooling over a raster pixel stream using one line buffer of partials.
// Define POOL_AVG_EN to add the pool_mode port and average pooling.
module stream_pool_layer
    import cnn_pool_pkg::*;
#(
    parameter int DATA_WIDTH = 69,
    parameter int CHANNELS   = 8,
    parameter int IN_X       = 24,
    parameter int IN_Y       = 24,
    parameter int STRIDE     = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           pool_enable,
    input  logic                           clear,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [CHANNELS*DATA_WIDTH-1:0] in_data,
`ifdef POOL_AVG_EN
    input  logic                           pool_mode,
`endif
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [CHANNELS*DATA_WIDTH-1:0] out_data,
    output logic                           out_last,
    output logic                           pool_done
);

    localparam int L         = clog2_stride(STRIDE);
`ifdef POOL_AVG_EN
    localparam int ACC_W     = DATA_WIDTH + 2*L;
`else
    localparam int ACC_W     = DATA_WIDTH;
`endif
    localparam int POOL_COLS = IN_Y / STRIDE;
    localparam int RW        = (IN_X > 1) ? $clog2(IN_X) : 1;
    localparam int CW        = (IN_Y > 1) ? $clog2(IN_Y) : 1;
    localparam int WW        = CHANNELS * DATA_WIDTH;
    localparam int AW        = CHANNELS * ACC_W;

    if (STRIDE < 2 || (STRIDE & (STRIDE - 1)) != 0 ||
        (IN_X % STRIDE) != 0 || (IN_Y % STRIDE) != 0) begin : g_cfg_err
        $error("stream_pool_layer: STRIDE must be a power of two >= 2 dividing IN_X and IN_Y");
    end

    state_e            state_q, state_d;
    mode_e             mode_q;
    logic [RW-1:0]     row_q;
    logic [CW-1:0]     col_q;
    logic [CW-L-1:0]   slot;
    logic              accept, emit, out_hs, last_pix;
    logic              sub_col_zero, win_col_end, sub_row_zero, sub_row_last;
    logic [AW-1:0]     sample_acc, partial_p0, red_ps, run_res, line_rd, merged, line_wr;
    logic [AW-1:0]     line_buf [POOL_COLS];

    function automatic logic [WW-1:0] window_result(input logic [AW-1:0] acc, input mode_e m);
        logic [ACC_W-1:0] v;
        window_result = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            v = acc[c*ACC_W +: ACC_W];
            if (m == POOL_AVG)
                v = v >> (2*L);
            window_result[c*DATA_WIDTH +: DATA_WIDTH] = v[DATA_WIDTH-1:0];
        end
    endfunction

`ifdef POOL_AVG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mode_q <= POOL_MAX;
        else if (state_q == IDLE && pool_enable && !clear)
            mode_q <= mode_e'(pool_mode);
    end
`else
    assign mode_q = POOL_MAX;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pool_enable)               state_d = RUN;
            RUN:     if (accept && last_pix)        state_d = FLUSH;
            FLUSH:   if (out_hs && out_last)        state_d = DONE;
            DONE:                                   state_d = IDLE;
            default:                                state_d = IDLE;
        endcase
        if (clear)
            state_d = IDLE;
    end

    always_comb begin
        in_ready  = (state_q == RUN) && (!out_valid || out_ready);
        pool_done = (state_q == DONE);
    end

    assign accept       = in_valid && in_ready;
    assign out_hs       = out_valid && out_ready;
    assign sub_col_zero = (col_q[L-1:0] == '0);
    assign win_col_end  = (col_q[L-1:0] == {L{1'b1}});
    assign sub_row_zero = (row_q[L-1:0] == '0);
    assign sub_row_last = (row_q[L-1:0] == {L{1'b1}});
    assign last_pix     = (row_q == RW'(IN_X-1)) && (col_q == CW'(IN_Y-1));
    assign slot         = col_q[CW-1:L];
    assign emit         = accept && !clear && win_col_end && sub_row_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
        end else if (clear || state_q == IDLE) begin
            row_q <= '0;
            col_q <= '0;
        end else if (accept) begin
            if (col_q == CW'(IN_Y-1)) begin
                col_q <= '0;
                row_q <= (row_q == RW'(IN_X-1)) ? '0 : row_q + 1'b1;
            end else begin
                col_q <= col_q + 1'b1;
            end
        end
    end

    // Stage p0: widen samples, fold along the window row, then across window rows.
    always_comb begin
        sample_acc = '0;
        for (int c = 0; c < CHANNELS; c++)
            sample_acc[c*ACC_W +: ACC_W] = ACC_W'(in_data[c*DATA_WIDTH +: DATA_WIDTH]);
    end

    pool_reduce #(.W(ACC_W), .CHANNELS(CHANNELS)) u_reduce_sample (
        .mode (mode_q),
        .a    (partial_p0),
        .b    (sample_acc),
        .y    (red_ps)
    );

    assign run_res = sub_col_zero ? sample_acc : red_ps;
    assign line_rd = line_buf[slot];

    pool_reduce #(.W(ACC_W), .CHANNELS(CHANNELS)) u_reduce_line (
        .mode (mode_q),
        .a    (line_rd),
        .b    (run_res),
        .y    (merged)
    );

    assign line_wr = sub_row_zero ? run_res : merged;

    always_ff @(posedge clk) begin
        if (accept) begin
            partial_p0 <= run_res;
            if (win_col_end)
                line_buf[slot] <= line_wr;
        end
    end

    // Stage p1: registered output word, held until the downstream handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else if (clear) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (emit) begin
            out_valid <= 1'b1;
            out_last  <= last_pix;
            out_data  <= window_result(merged, mode_q);
        end else if (out_hs) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_pool_layer.sv
// Directed bench for stream_pool_layer on a 4x4, 2-channel, 8-bit frame with 2x2 windows.
module tb_stream_pool_layer;

    localparam int DW = 8;
    localparam int CH = 2;
    localparam int NX = 4;
    localparam int NY = 4;
    localparam int S  = 2;
    localparam int NPIX = NX * NY;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n, pool_enable, clear, in_valid, in_ready;
    logic             out_valid, out_ready, out_last, pool_done;
    logic [CH*DW-1:0] in_data, out_data;
`ifdef POOL_AVG_EN
    logic             pool_mode;
`endif

    stream_pool_layer #(
        .DATA_WIDTH(DW), .CHANNELS(CH), .IN_X(NX), .IN_Y(NY), .STRIDE(S)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pool_enable (pool_enable),
        .clear       (clear),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
`ifdef POOL_AVG_EN
        .pool_mode   (pool_mode),
`endif
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .pool_done   (pool_done)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int done_cnt, done_cyc, last_hs_cyc;
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic       ql[$];

    logic [7:0] E_MAX0 [4] = '{8'd5, 8'd7, 8'd13, 8'd15};
    logic [7:0] E_MAX1 [4] = '{8'd15, 8'd13, 8'd7, 8'd5};
    logic [7:0] E_ZERO [4] = '{8'd0, 8'd0, 8'd0, 8'd0};
    logic [7:0] E_FULL [4] = '{8'd255, 8'd255, 8'd255, 8'd255};
    logic [7:0] E_AVG0 [4] = '{8'd2, 8'd4, 8'd10, 8'd12};
    logic [7:0] E_AVG1 [4] = '{8'd12, 8'd10, 8'd4, 8'd2};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                q0.push_back(out_data[7:0]);
                q1.push_back(out_data[15:8]);
                ql.push_back(out_last);
                if (out_last) last_hs_cyc = cyc;
            end
            if (pool_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    function automatic logic [15:0] pix(input int kind, input int i);
        logic [7:0] a;
        logic [7:0] b;
        a = 8'(i);
        b = 8'(15 - i);
        case (kind)
            0:       return {b, a};
            1:       return 16'h0000;
            default: return 16'hFFFF;
        endcase
    endfunction

    task automatic clear_log();
        q0.delete();
        q1.delete();
        ql.delete();
        done_cnt    = 0;
        done_cyc    = -100;
        last_hs_cyc = 0;
    endtask

    task automatic start_frame();
        pool_enable = 1'b1;
        @(posedge clk);
        #1 pool_enable = 1'b0;
    endtask

    task automatic send_pixels(input int kind, input int n, input int abort_idx);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = pix(kind, i);
            if (i == abort_idx) begin
                clear = 1'b1;
                @(posedge clk);
                #1 clear = 1'b0;
                in_valid = 1'b0;
                return;
            end
            begin
                int t = 0;
                @(negedge clk);
                while (!in_ready && t < 200) begin
                    @(negedge clk);
                    t++;
                end
                if (t >= 200) chk("accept_timeout", 32'(in_ready), 1);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while (done_cnt == 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("pool_done_seen", 32'(done_cnt != 0), 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_frame(input string tag, input logic [7:0] e0 [4], input logic [7:0] e1 [4]);
        chk({tag, "_count"}, 32'(q0.size()), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < q0.size()) begin
                chk($sformatf("%s_ch0_%0d", tag, i), 32'(q0[i]), 32'(e0[i]));
                chk($sformatf("%s_ch1_%0d", tag, i), 32'(q1[i]), 32'(e1[i]));
                chk($sformatf("%s_last_%0d", tag, i), 32'(ql[i]), 32'(i == 3));
            end
        end
        chk({tag, "_done_pulses"}, 32'(done_cnt), 1);
        chk({tag, "_done_gap"}, 32'(done_cyc - last_hs_cyc), 1);
    endtask

    task automatic run_frame(input int kind);
        clear_log();
        start_frame();
        send_pixels(kind, NPIX, -1);
        wait_done();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; pool_enable = 1'b0; clear = 1'b0; in_valid = 1'b0;
        in_data = '0; out_ready = 1'b1;
`ifdef POOL_AVG_EN
        pool_mode = 1'b0;
`endif
        clear_log();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_last", 32'(out_last), 0);
        chk("rst_pool_done", 32'(pool_done), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Case 1: max pooling of the ramp frame.
        run_frame(0);
        check_frame("max", E_MAX0, E_MAX1);

        // Case 2: backpressure right after the first emitted word.
        clear_log();
        out_ready = 1'b0;
        fork
            begin
                int t = 0;
                @(negedge clk);
                while (!out_valid && t < 200) begin
                    @(negedge clk);
                    t++;
                end
                chk("bp_first_valid", 32'(out_valid), 1);
                for (int k = 0; k < 5; k++) begin
                    chk("bp_in_ready", 32'(in_ready), 0);
                    chk("bp_hold_ch0", 32'(out_data[7:0]), 5);
                    chk("bp_hold_valid", 32'(out_valid), 1);
                    @(negedge clk);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
            begin
                start_frame();
                send_pixels(0, NPIX, -1);
                wait_done();
            end
        join
        check_frame("bp", E_MAX0, E_MAX1);

        // Case 3: all-zero and all-255 frames.
        run_frame(1);
        check_frame("zero", E_ZERO, E_ZERO);
        run_frame(2);
        check_frame("full", E_FULL, E_FULL);

        // Case 4: clear while a word is pending, then a clean frame.
        clear_log();
        out_ready = 1'b0;
        start_frame();
        send_pixels(0, NPIX, 6);
        @(negedge clk);
        chk("clr_out_valid", 32'(out_valid), 0);
        chk("clr_in_ready", 32'(in_ready), 0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("clr_no_output", 32'(q0.size()), 0);
        chk("clr_no_done", 32'(done_cnt), 0);
        run_frame(0);
        check_frame("after_clr", E_MAX0, E_MAX1);

        // Case 5: asynchronous reset mid-frame with a word pending.
        clear_log();
        start_frame();
        send_pixels(0, 6, -1);
        chk("arst_pre_valid", 32'(out_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 0);
        chk("arst_out_data", 32'(out_data), 0);
        chk("arst_out_last", 32'(out_last), 0);
        chk("arst_in_ready", 32'(in_ready), 0);
        chk("arst_pool_done", 32'(pool_done), 0);
        #1 rst_n = 1'b1;
        in_valid = 1'b1;
        in_data  = pix(0, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("arst_idle_in_ready", 32'(in_ready), 0);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk("arst_no_output", 32'(q0.size()), 0);
        run_frame(0);
        check_frame("after_arst", E_MAX0, E_MAX1);

`ifdef POOL_AVG_EN
        // Case 6: average pooling of the ramp frame.
        pool_mode = 1'b1;
        run_frame(0);
        pool_mode = 1'b0;
        check_frame("avg", E_AVG0, E_AVG1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
